joystick_conditioner: RTL and testbench

//  Conditions the raw joystick/button inputs before display_top consumes them as
//  Wup, Wdown, Wleft, Wright and Wbtn.

---
 rtl/joystick_conditioner.sv | 91 +++++++++
 tb/tb_joystick_conditioner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_conditioner.sv
// Joystick/button front end: 2-FF synchronizer, per-channel debounce, opposing-direction
// neutralisation and a one-cycle button press pulse.
`timescale 1ns/1ps

module joystick_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_up,
    input  logic raw_down,
    input  logic raw_left,
    input  logic raw_right,
    input  logic raw_btn,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic btn,
    output logic btn_pulse
);

    localparam int unsigned NCH    = 5;
    localparam int unsigned CH_UP  = 0;
    localparam int unsigned CH_DN  = 1;
    localparam int unsigned CH_LT  = 2;
    localparam int unsigned CH_RT  = 3;
    localparam int unsigned CH_BTN = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]   raw_vec;
    logic [NCH-1:0]   in_vec;
    logic [NCH-1:0]   s1;
    logic [NCH-1:0]   s2;
    logic [NCH-1:0]   stable;
    logic [CNT_W-1:0] cnt [NCH];
    logic             btn_prev;

    assign raw_vec = {raw_btn, raw_right, raw_left, raw_down, raw_up};
    assign in_vec  = ACTIVE_LOW ? ~raw_vec : raw_vec;

    // Only place raw pins are sampled; everything downstream uses s2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_vec;
            s2 <= s1;
        end
    end

    // A new level must persist DEBOUNCE_CYCLES edges; any return to the old level restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_prev <= 1'b0;
        end else begin
            btn_prev <= stable[CH_BTN];
        end
    end

    assign up        = stable[CH_UP] & ~stable[CH_DN];
    assign down      = stable[CH_DN] & ~stable[CH_UP];
    assign left      = stable[CH_LT] & ~stable[CH_RT];
    assign right     = stable[CH_RT] & ~stable[CH_LT];
    assign btn       = stable[CH_BTN];
    assign btn_pulse = stable[CH_BTN] & ~btn_prev;

endmodule

// File: tb/tb_joystick_conditioner.sv
// Bench for joystick_conditioner: two instances (active-high and active-low pins) checked
// every cycle against a reference model, plus table vectors and timed corner sequences.
`timescale 1ns/1ps

module tb_joystick_conditioner;

    localparam int unsigned DEB = 4;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic btn;
        logic btn_pulse;
    } out_t;

    typedef struct {
        logic [4:0] raw;     // {btn, right, left, down, up}
        int         cycles;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic r_up, r_down, r_left, r_right, r_btn;
    logic o0_up, o0_down, o0_left, o0_right, o0_btn, o0_pulse;
    logic o1_up, o1_down, o1_left, o1_right, o1_btn, o1_pulse;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    joystick_conditioner #(.DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .reset(reset),
        .raw_up(r_up), .raw_down(r_down), .raw_left(r_left), .raw_right(r_right), .raw_btn(r_btn),
        .up(o0_up), .down(o0_down), .left(o0_left), .right(o0_right), .btn(o0_btn), .btn_pulse(o0_pulse)
    );

    joystick_conditioner #(.DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .reset(reset),
        .raw_up(~r_up), .raw_down(~r_down), .raw_left(~r_left), .raw_right(~r_right), .raw_btn(~r_btn),
        .up(o1_up), .down(o1_down), .left(o1_left), .right(o1_right), .btn(o1_btn), .btn_pulse(o1_pulse)
    );

    function automatic out_t dut_out(input int d);
        out_t o;
        if (d == 0) o = {o0_up, o0_down, o0_left, o0_right, o0_btn, o0_pulse};
        else        o = {o1_up, o1_down, o1_left, o1_right, o1_btn, o1_pulse};
        return o;
    endfunction

    function automatic logic pick(input out_t o, input int idx);
        case (idx)
            0:       return o.up;
            1:       return o.down;
            2:       return o.left;
            3:       return o.right;
            4:       return o.btn;
            default: return o.btn_pulse;
        endcase
    endfunction

    task automatic check_out(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the synced pin has disagreed for DEB edges in a row.
    logic [4:0] m_s1, m_s2, m_st;
    int         m_run [5];
    logic       m_prev;
    out_t       sb [$];

    function automatic out_t model_out();
        out_t o;
        o.up        = m_st[0] & ~m_st[1];
        o.down      = m_st[1] & ~m_st[0];
        o.left      = m_st[2] & ~m_st[3];
        o.right     = m_st[3] & ~m_st[2];
        o.btn       = m_st[4];
        o.btn_pulse = m_st[4] & ~m_prev;
        return o;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_prev = 1'b0;
            for (int c = 0; c < 5; c++) m_run[c] = 0;
            sb.delete();
            sb.push_back(out_t'(0));
        end else begin
            m_prev = m_st[4];
            for (int c = 0; c < 5; c++) begin
                if (m_s2[c] != m_st[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        m_st[c]  = m_s2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {r_btn, r_right, r_left, r_down, r_up};
            sb.push_back(model_out());
        end
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            out_t e;
            e = sb.pop_front();
            check_out("sb_active_high", dut_out(0), e);
            check_out("sb_active_low", dut_out(1), e);
        end
    end

    task automatic set_raw(input logic [4:0] v);
        {r_btn, r_right, r_left, r_down, r_up} = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Edges until output idx reaches lvl; -1 if the bound expires.
    task automatic count_until(input int idx, input logic lvl, input int max, output int n);
        bit found = 0;
        n = 0;
        while (n < max && !found) begin
            tick(1);
            n++;
            if (pick(dut_out(0), idx) === lvl) found = 1;
        end
        if (!found) n = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t tbl [10];
    int   n, hi_cnt, pulse_cnt;
    bit   seen;

    initial begin
        tbl[0] = '{5'b00000, 8, 6'b000000};
        tbl[1] = '{5'b00001, 8, 6'b100000};
        tbl[2] = '{5'b00011, 8, 6'b000000};
        tbl[3] = '{5'b00001, 8, 6'b100000};
        tbl[4] = '{5'b00101, 8, 6'b101000};
        tbl[5] = '{5'b01100, 8, 6'b000000};
        tbl[6] = '{5'b01010, 8, 6'b010100};
        tbl[7] = '{5'b10000, 8, 6'b000010};
        tbl[8] = '{5'b11111, 8, 6'b000010};
        tbl[9] = '{5'b00000, 8, 6'b000000};

        // Reset held with every pin active
        reset = 1'b1;
        set_raw(5'b11111);
        tick(3);
        check_out("reset_hi", dut_out(0), out_t'(0));
        check_out("reset_lo", dut_out(1), out_t'(0));

        // Release with up/left/btn held: all rise on the 6th edge after release
        set_raw(5'b10101);
        reset = 1'b0;
        count_until(0, 1'b1, 20, n);
        check_int("t1_up_latency", n, 6);
        check_int("t1_left_with_up", int'(o0_left), 1);
        check_int("t1_pulse_first", int'(o0_pulse), 1);
        tick(1);
        check_int("t1_pulse_gone", int'(o0_pulse), 0);
        set_raw(5'b00000);
        tick(8);

        foreach (tbl[i]) begin
            set_raw(tbl[i].raw);
            tick(tbl[i].cycles);
            check_out($sformatf("table_%0d", i), dut_out(0), tbl[i].exp);
        end

        // Bounce on left
        set_raw(5'b00100); tick(2);
        check_int("t2_bounce_a", int'(o0_left), 0);
        set_raw(5'b00000); tick(2);
        check_int("t2_bounce_b", int'(o0_left), 0);
        set_raw(5'b00100);
        count_until(2, 1'b1, 20, n);
        check_int("t2_left_latency", n, 6);
        set_raw(5'b00000); tick(8);

        // Right glitch of DEB-1 cycles is rejected
        set_raw(5'b01000); tick(3);
        set_raw(5'b00000);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (o0_right) seen = 1;
        end
        check_int("t3_glitch_rejected", int'(seen), 0);

        // Exactly DEB cycles is accepted; release latency matches press latency
        set_raw(5'b01000); tick(4);
        set_raw(5'b00000);
        count_until(3, 1'b1, 20, n);
        check_int("t3_min_pulse_rise", n, 2);
        count_until(3, 1'b0, 20, n);
        check_int("t3_min_pulse_fall", n, 4);
        tick(4);

        // Button held 20 cycles
        hi_cnt = 0; pulse_cnt = 0;
        set_raw(5'b10000);
        for (int i = 0; i < 40; i++) begin
            if (i == 20) set_raw(5'b00000);
            tick(1);
            if (o0_btn) hi_cnt++;
            if (o0_pulse) pulse_cnt++;
        end
        check_int("t5_btn_high_span", hi_cnt, 20);
        check_int("t5_pulse_count", pulse_cnt, 1);

        // Async reset one cycle into a button press
        set_raw(5'b10000);
        tick(1);
        reset = 1'b1;
        #1;
        check_out("t6_reset_now_hi", dut_out(0), out_t'(0));
        check_out("t6_reset_now_lo", dut_out(1), out_t'(0));
        tick(2);
        reset = 1'b0;
        count_until(5, 1'b1, 20, n);
        check_int("t6_pulse_latency", n, 6);
        pulse_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (o0_pulse) pulse_cnt++;
        end
        check_int("t6_no_repeat_pulse", pulse_cnt, 0);

        set_raw(5'b00000);
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
